// File: rtl/letc_core_limp_arbiter.sv
// letc_core_limp_arbiter
//
// Round-robin arbiter that shares the single LIMP memory request channel
// between the MMU (index 0), the instruction cache (index 1) and the data
// cache (index 2). A grant is held until the downstream side completes the
// transfer (valid && ready), so a requester is never pre-empted mid-transfer.
// On completion the next grant is chosen in the same cycle with the completing
// requester masked out, so there is no bubble between different requesters.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_valid / o_req_ready     per-requester handshake (ready is one-hot or zero)
//   i_req_wen_nren, i_req_size,
//   i_req_addr, i_req_wdata       per-requester request fields
//   o_req_rdata                   downstream read data, broadcast to all requesters
//   o_valid / i_ready             downstream handshake
//   o_wen_nren, o_size, o_addr,
//   o_wdata                       request fields of the granted requester
//   i_rdata                       downstream read data
//   o_grant                       one-hot current grant, zero when idle

package letc_pkg;
    typedef logic [33:0] paddr_t;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALFWORD = 2'b01,
        SIZE_WORD     = 2'b10
    } size_e;
endpackage

// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no grant held; arbitrating from rr_ptr over i_req_valid
// ST_GRANTED | grant_q owns the channel until its transfer completes
module letc_core_limp_arbiter
    import letc_pkg::*;
#(
    parameter int NUM_REQUESTERS = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,

    input  logic [NUM_REQUESTERS-1:0] i_req_valid,
    output logic [NUM_REQUESTERS-1:0] o_req_ready,
    input  logic [NUM_REQUESTERS-1:0] i_req_wen_nren,
    input  size_e                     i_req_size  [NUM_REQUESTERS],
    input  paddr_t                    i_req_addr  [NUM_REQUESTERS],
    input  word_t                     i_req_wdata [NUM_REQUESTERS],
    output word_t                     o_req_rdata [NUM_REQUESTERS],

    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_wen_nren,
    output size_e                     o_size,
    output paddr_t                    o_addr,
    output word_t                     o_wdata,
    input  word_t                     i_rdata,

    output logic [NUM_REQUESTERS-1:0] o_grant
);

    localparam int IDX_W = $clog2(NUM_REQUESTERS);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_e;

    typedef struct packed {
        logic found;
        idx_t idx;
    } pick_t;

    state_e state_q, state_d;
    idx_t   grant_q, grant_d;
    idx_t   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQUESTERS-1:0] masked_valid;
    logic                      granted_valid;
    pick_t                     idle_pick;
    pick_t                     next_pick;

    // Index increment that wraps at NUM_REQUESTERS, which need not be a power of two.
    function automatic idx_t wrap_inc(input idx_t idx);
        idx_t result;
        if (int'(idx) == NUM_REQUESTERS - 1) begin
            result = '0;
        end else begin
            result = idx + idx_t'(1);
        end
        return result;
    endfunction

    // First set bit of req, searching upward from start and wrapping.
    function automatic pick_t rr_search(input logic [NUM_REQUESTERS-1:0] req, input idx_t start);
        pick_t pick;
        idx_t  idx;
        pick = '0;
        idx  = start;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (!pick.found && req[idx]) begin
                pick.found = 1'b1;
                pick.idx   = idx;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        granted_valid = i_req_valid[grant_q];

        // The completing requester is masked so its next request waits a cycle
        // and then competes at lowest priority behind the new rr_ptr.
        masked_valid          = i_req_valid;
        masked_valid[grant_q] = 1'b0;

        idle_pick = rr_search(i_req_valid, rr_ptr_q);
        next_pick = rr_search(masked_valid, wrap_inc(grant_q));

        case (state_q)
            ST_IDLE: begin
                if (idle_pick.found) begin
                    state_d = ST_GRANTED;
                    grant_d = idle_pick.idx;
                end
            end
            ST_GRANTED: begin
                if (granted_valid && i_ready) begin
                    rr_ptr_d = wrap_inc(grant_q);
                    if (next_pick.found) begin
                        grant_d = next_pick.idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_valid     = 1'b0;
        o_grant     = '0;
        o_req_ready = '0;
        if (state_q == ST_GRANTED) begin
            o_valid              = i_req_valid[grant_q];
            o_grant[grant_q]     = 1'b1;
            o_req_ready[grant_q] = i_req_valid[grant_q] & i_ready;
        end
    end

    // Field mux follows grant_q even when idle; it resets to 0 so the
    // downstream side never sees X.
    assign o_wen_nren = i_req_wen_nren[grant_q];
    assign o_size     = i_req_size[grant_q];
    assign o_addr     = i_req_addr[grant_q];
    assign o_wdata    = i_req_wdata[grant_q];

    always_comb begin
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            o_req_rdata[i] = i_rdata;
        end
    end

    a_ready_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_req_ready));

    a_grant_shape: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state_q == ST_GRANTED) ? $onehot(o_grant) : (o_grant == '0));

    // A granted requester must not withdraw its request before completion.
    a_valid_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state_q == ST_GRANTED && i_req_valid[grant_q] && !i_ready) |=> i_req_valid[grant_q]);

    a_rr_ptr_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        int'(rr_ptr_q) < NUM_REQUESTERS);

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
module tb_letc_core_limp_arbiter;
    import letc_pkg::*;

    localparam int N = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N-1:0] req_wen;
    size_e        req_size  [N];
    paddr_t       req_addr  [N];
    word_t        req_wdata [N];
    word_t        req_rdata [N];
    logic         o_valid;
    logic         ready;
    logic         o_wen;
    size_e        o_size;
    paddr_t       o_addr;
    word_t        o_wdata;
    word_t        rdata;
    logic [N-1:0] o_grant;

    int checks;
    int errors;

    // Reference model: current owner (-1 when nobody owns the channel) and
    // the index that has first claim at the next arbitration.
    int m_grant;
    int m_rr;

    letc_core_limp_arbiter #(.NUM_REQUESTERS(N)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_wen_nren (req_wen),
        .i_req_size     (req_size),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_req_rdata    (req_rdata),
        .o_valid        (o_valid),
        .i_ready        (ready),
        .o_wen_nren     (o_wen),
        .o_size         (o_size),
        .o_addr         (o_addr),
        .o_wdata        (o_wdata),
        .i_rdata        (rdata),
        .o_grant        (o_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_update();
        logic [N-1:0] others;
        if (!rst_n) begin
            m_grant = -1;
            m_rr    = 0;
        end else if (m_grant < 0) begin
            m_grant = rr_pick(req_valid, m_rr);
        end else if (req_valid[m_grant] && ready) begin
            others          = req_valid;
            others[m_grant] = 1'b0;
            m_rr            = (m_grant + 1) % N;
            m_grant         = rr_pick(others, m_rr);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_wen   = '0;
        ready     = 1'b0;
        rdata     = '0;
        for (int i = 0; i < N; i++) begin
            req_size[i]  = SIZE_WORD;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        m_grant = -1;
        m_rr    = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        req_addr[0]  = 34'h1_2345_6788;
        req_wdata[0] = 32'hCAFE_F00D;
        m_grant = -1;
        m_rr    = 0;
        #3;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
        checks++; if (o_grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", o_grant); end
        checks++; if (o_addr !== 34'h1_2345_6788) begin errors++; $display("FAIL reset_addr: got %h expected 123456788", o_addr); end
        checks++; if (o_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL reset_wdata: got %h expected cafef00d", o_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", o_valid); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid   = 3'b010;
        req_addr[1] = 34'h0_8000_0004;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_latency: got %b expected 0", o_valid); end
        tick();
        #1;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", o_valid); end
        checks++; if (o_addr !== 34'h0_8000_0004) begin errors++; $display("FAIL single_addr: got %h expected 080000004", o_addr); end
        checks++; if (o_grant !== 3'b010) begin errors++; $display("FAIL single_grant: got %b expected 010", o_grant); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL single_ready_early: got %b expected 000", req_ready); end
        ready = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b expected 010", req_ready); end
        tick();
        req_valid = 3'b000;
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL single_ready_once: got %b expected 000", req_ready); end
        checks++; if (o_grant !== 3'b000) begin errors++; $display("FAIL single_idle: got %b expected 000", o_grant); end
        // rr_ptr should now be 2, so an all-request burst goes to the dcache first.
        req_valid = 3'b111;
        ready     = 1'b0;
        tick();
        #1;
        checks++; if (o_grant !== 3'b100) begin errors++; $display("FAIL single_rr_ptr: got %b expected 100", o_grant); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp;
        do_reset();
        req_valid = 3'b111;
        ready     = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fair_latency: got %b expected 0", o_valid); end
        for (int i = 0; i < 9; i++) begin
            tick();
            #1;
            exp = 3'(1 << (i % N));
            checks++; if (o_grant !== exp) begin errors++; $display("FAIL fair_grant[%0d]: got %b expected %b", i, o_grant, exp); end
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL fair_ready[%0d]: got %b expected %b", i, req_ready, exp); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        req_valid    = 3'b100;
        req_wen[2]   = 1'b1;
        req_wdata[2] = 32'hDEAD_BEEF;
        req_addr[2]  = 34'h2_0000_0100;
        req_addr[0]  = 34'h0_0000_0040;
        req_wdata[0] = 32'h1111_2222;
        tick();
        for (int i = 0; i < 10; i++) begin
            req_valid = 3'b101;
            #1;
            checks++; if (o_grant !== 3'b100) begin errors++; $display("FAIL stall_grant[%0d]: got %b expected 100", i, o_grant); end
            checks++; if (o_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_wdata[%0d]: got %h expected deadbeef", i, o_wdata); end
            checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 000", i, req_ready); end
            checks++; if (o_wen !== 1'b1) begin errors++; $display("FAIL stall_wen[%0d]: got %b expected 1", i, o_wen); end
            tick();
        end
        ready = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL stall_release: got %b expected 100", req_ready); end
        tick();
        req_valid = 3'b001;
        ready     = 1'b0;
        #1;
        checks++; if (o_grant !== 3'b001) begin errors++; $display("FAIL stall_next_grant: got %b expected 001", o_grant); end
        checks++; if (o_addr !== 34'h0_0000_0040) begin errors++; $display("FAIL stall_next_addr: got %h expected 000000040", o_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 3'b001;
        ready     = 1'b1;
        tick();
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL b2b_first: got %b expected 001", req_ready); end
        tick();
        #1;
        checks++; if (o_grant !== 3'b000) begin errors++; $display("FAIL b2b_gap_grant: got %b expected 000", o_grant); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL b2b_gap_ready: got %b expected 000", req_ready); end
        tick();
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL b2b_regrant: got %b expected 001", req_ready); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req_valid = 3'b001;
        tick();
        #1;
        checks++; if (o_grant !== 3'b001) begin errors++; $display("FAIL midrst_pre: got %b expected 001", o_grant); end
        #1;
        rst_n   = 1'b0;
        m_grant = -1;
        m_rr    = 0;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", o_valid); end
        checks++; if (o_grant !== 3'b000) begin errors++; $display("FAIL midrst_grant: got %b expected 000", o_grant); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL midrst_ready: got %b expected 000", req_ready); end
        @(negedge clk);
        req_valid = 3'b110;
        rst_n     = 1'b1;
        tick();
        #1;
        checks++; if (o_grant !== 3'b010) begin errors++; $display("FAIL midrst_after: got %b expected 010", o_grant); end
    endtask

    task automatic test_read_data();
        do_reset();
        req_valid = 3'b010;
        tick();
        req_valid = 3'b111;
        rdata     = 32'h1234_5678;
        ready     = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++; if (req_rdata[i] !== 32'h1234_5678) begin errors++; $display("FAIL rdata[%0d]: got %h expected 12345678", i, req_rdata[i]); end
        end
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL rdata_ready: got %b expected 010", req_ready); end
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ready;
        logic         exp_valid;
        logic [63:0]  tmp64;
        int           done_cnt [N];
        do_reset();
        pend = '0;
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i]      = 1'b1;
                    req_wen[i]   = 1'($urandom_range(0, 1));
                    req_size[i]  = size_e'($urandom_range(0, 2));
                    tmp64        = {$urandom, $urandom};
                    req_addr[i]  = tmp64[33:0];
                    req_wdata[i] = $urandom;
                end
            end
            req_valid = pend;
            ready     = ($urandom_range(0, 3) != 0);
            rdata     = $urandom;
            #1;
            exp_valid = (m_grant >= 0) && req_valid[m_grant];
            exp_grant = (m_grant >= 0) ? 3'(1 << m_grant) : 3'b000;
            exp_ready = (exp_valid && ready) ? exp_grant : 3'b000;
            checks++; if (o_valid !== exp_valid) begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", cyc, o_valid, exp_valid); end
            checks++; if (o_grant !== exp_grant) begin errors++; $display("FAIL rand_grant@%0d: got %b expected %b", cyc, o_grant, exp_grant); end
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready@%0d: got %b expected %b", cyc, req_ready, exp_ready); end
            checks++; if (req_rdata[cyc % N] !== rdata) begin errors++; $display("FAIL rand_rdata@%0d: got %h expected %h", cyc, req_rdata[cyc % N], rdata); end
            if (m_grant >= 0) begin
                checks++; if (o_addr !== req_addr[m_grant]) begin errors++; $display("FAIL rand_addr@%0d: got %h expected %h", cyc, o_addr, req_addr[m_grant]); end
                checks++; if (o_wdata !== req_wdata[m_grant]) begin errors++; $display("FAIL rand_wdata@%0d: got %h expected %h", cyc, o_wdata, req_wdata[m_grant]); end
                checks++; if (o_size !== req_size[m_grant]) begin errors++; $display("FAIL rand_size@%0d: got %0d expected %0d", cyc, o_size, req_size[m_grant]); end
                checks++; if (o_wen !== req_wen[m_grant]) begin errors++; $display("FAIL rand_wen@%0d: got %b expected %b", cyc, o_wen, req_wen[m_grant]); end
            end
            for (int i = 0; i < N; i++) begin
                if (exp_ready[i]) begin
                    pend[i] = 1'b0;
                    done_cnt[i]++;
                end
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            checks++; if (done_cnt[i] == 0) begin errors++; $display("FAIL rand_starved[%0d]: got 0 completions expected more than 0", i); end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_grant = -1;
        m_rr    = 0;
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_back_to_back();
        test_reset_mid_op();
        test_read_data();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
